// File: rtl/axi4lite_regfile_slave.sv
// AXI4-Lite slave exposing 2**ADDR_WIDTH byte-strobed registers with independent read/write FSMs.
// Optional: define AXI4LITE_REGFILE_RO_ID_EN to make the top register a read-only ID (SLVERR on write).
module axi4lite_regfile_slave #(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_areset,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready
);

  localparam int unsigned NUM_REGS   = 2 ** ADDR_WIDTH;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e r_wstate, w_wstate_next;
  r_state_e r_rstate, w_rstate_next;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic                  r_aw_held;
  logic                  r_w_held;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic [1:0]            r_bresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_b_hs;
  logic                  w_r_hs;
  logic                  w_wr_ro;
  logic [DATA_WIDTH-1:0] w_rd_value;

  assign s_axi_awready = (r_wstate == W_IDLE) && !r_aw_held;
  assign s_axi_wready  = (r_wstate == W_IDLE) && !r_w_held;
  assign s_axi_bvalid  = (r_wstate == W_RESP);
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = (r_rstate == R_IDLE);
  assign s_axi_rvalid  = (r_rstate == R_DATA);
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = 2'b00;

  assign w_aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_w_hs  = s_axi_wvalid && s_axi_wready;
  assign w_ar_hs = s_axi_arvalid && s_axi_arready;
  assign w_b_hs  = s_axi_bvalid && s_axi_bready;
  assign w_r_hs  = s_axi_rvalid && s_axi_rready;

`ifdef AXI4LITE_REGFILE_RO_ID_EN
  localparam logic [DATA_WIDTH-1:0] ID_VALUE = {STRB_WIDTH{8'hA5}};
  logic w_rd_ro;
  assign w_wr_ro    = (r_awaddr == {ADDR_WIDTH{1'b1}});
  assign w_rd_ro    = (s_axi_araddr == {ADDR_WIDTH{1'b1}});
  assign w_rd_value = w_rd_ro ? ID_VALUE : r_regs[s_axi_araddr];
`else
  assign w_wr_ro    = 1'b0;
  assign w_rd_value = r_regs[s_axi_araddr];
`endif

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_next;
      r_rstate <= w_rstate_next;
    end
  end

  // Commit once both channels are held, counting a handshake landing on this same edge.
  always_comb begin
    w_wstate_next = r_wstate;
    unique case (r_wstate)
      W_IDLE: begin
        if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) begin
          w_wstate_next = W_COMMIT;
        end
      end
      W_COMMIT: w_wstate_next = W_RESP;
      W_RESP: begin
        if (w_b_hs) begin
          w_wstate_next = W_IDLE;
        end
      end
      default: w_wstate_next = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_next = r_rstate;
    unique case (r_rstate)
      R_IDLE: begin
        if (w_ar_hs) begin
          w_rstate_next = R_DATA;
        end
      end
      R_DATA: begin
        if (w_r_hs) begin
          w_rstate_next = R_IDLE;
        end
      end
      default: w_rstate_next = R_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= 2'b00;
      r_rdata   <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= s_axi_awaddr;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axi_wdata;
        r_wstrb  <= s_axi_wstrb;
      end
      if (r_wstate == W_COMMIT) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bresp   <= w_wr_ro ? 2'b10 : 2'b00;
        if (!w_wr_ro) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (r_wstrb[b]) begin
              r_regs[r_awaddr][b*8 +: 8] <= r_wdata[b*8 +: 8];
            end
          end
        end
      end
      // Nonblocking update means a same-edge commit is not visible here: pre-write value returned.
      if (w_ar_hs) begin
        r_rdata <= w_rd_value;
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_regfile_slave.sv
// Directed bench for axi4lite_regfile_slave: vector table plus hand-written multi-cycle sequences.
module tb_axi4lite_regfile_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] awaddr = '0;
  logic       awvalid = 1'b0;
  logic       awready;
  logic [7:0] wdata = '0;
  logic [0:0] wstrb = '0;
  logic       wvalid = 1'b0;
  logic       wready;
  logic [1:0] bresp;
  logic       bvalid;
  logic       bready = 1'b0;
  logic [1:0] araddr = '0;
  logic       arvalid = 1'b0;
  logic       arready;
  logic [7:0] rdata;
  logic [1:0] rresp;
  logic       rvalid;
  logic       rready = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi4lite_regfile_slave #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (rst),
    .s_axi_awaddr (awaddr),
    .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata  (wdata),
    .s_axi_wstrb  (wstrb),
    .s_axi_wvalid (wvalid),
    .s_axi_wready (wready),
    .s_axi_bresp  (bresp),
    .s_axi_bvalid (bvalid),
    .s_axi_bready (bready),
    .s_axi_araddr (araddr),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rdata  (rdata),
    .s_axi_rresp  (rresp),
    .s_axi_rvalid (rvalid),
    .s_axi_rready (rready)
  );

  typedef struct {
    bit         is_wr;
    logic [1:0] addr;
    logic [7:0] data;
    logic [0:0] strb;
    logic [7:0] exp;  // bresp for writes, rdata for reads
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " awready"}, 32'(awready), 32'd1);
    chk({tag, " wready"}, 32'(wready), 32'd1);
    chk({tag, " arready"}, 32'(arready), 32'd1);
    chk({tag, " bvalid"}, 32'(bvalid), 32'd0);
    chk({tag, " rvalid"}, 32'(rvalid), 32'd0);
    chk({tag, " bresp"}, 32'(bresp), 32'd0);
    chk({tag, " rresp"}, 32'(rresp), 32'd0);
    chk({tag, " rdata"}, 32'(rdata), 32'd0);
  endtask

  // AW and W in the same cycle; bvalid must appear exactly one cycle after the handshake edge.
  task automatic do_write(input logic [1:0] a, input logic [7:0] d, input logic [0:0] s,
                          input logic [1:0] exp_bresp, input string name);
    @(negedge clk);
    chk({name, " awready"}, 32'(awready), 32'd1);
    chk({name, " wready"}, 32'(wready), 32'd1);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk({name, " bvalid early"}, 32'(bvalid), 32'd0);
    @(negedge clk);
    chk({name, " bvalid"}, 32'(bvalid), 32'd1);
    chk({name, " bresp"}, 32'(bresp), 32'(exp_bresp));
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk({name, " bvalid clear"}, 32'(bvalid), 32'd0);
  endtask

  task automatic do_read(input logic [1:0] a, input logic [7:0] exp_d, input string name);
    @(negedge clk);
    chk({name, " arready"}, 32'(arready), 32'd1);
    araddr = a; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    chk({name, " rvalid"}, 32'(rvalid), 32'd1);
    chk({name, " rdata"}, 32'(rdata), 32'(exp_d));
    chk({name, " rresp"}, 32'(rresp), 32'd0);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk({name, " rvalid clear"}, 32'(rvalid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'd1, 8'h3C, 1'b1, 8'h00};
    vecs[1] = '{1'b0, 2'd1, 8'h00, 1'b0, 8'h3C};
    vecs[2] = '{1'b1, 2'd0, 8'h11, 1'b1, 8'h00};
    vecs[3] = '{1'b1, 2'd1, 8'h77, 1'b0, 8'h00};  // zero strobe: response, no update
    vecs[4] = '{1'b0, 2'd1, 8'h00, 1'b0, 8'h3C};
    vecs[5] = '{1'b0, 2'd0, 8'h00, 1'b0, 8'h11};
`ifdef AXI4LITE_REGFILE_RO_ID_EN
    vecs[6] = '{1'b1, 2'd3, 8'hFF, 1'b1, 8'h02};
    vecs[7] = '{1'b0, 2'd3, 8'h00, 1'b0, 8'hA5};
`else
    vecs[6] = '{1'b1, 2'd3, 8'hFF, 1'b1, 8'h00};
    vecs[7] = '{1'b0, 2'd3, 8'h00, 1'b0, 8'hFF};
`endif
    vecs[8] = '{1'b0, 2'd2, 8'h00, 1'b0, 8'h00};

    #1;
    chk_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp[1:0],
                 $sformatf("vec%0d wr", i));
      end else begin
        do_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d rd", i));
      end
    end

    // W three cycles before AW, then bready held low for five cycles.
    @(negedge clk);
    wdata = 8'h5A; wstrb = 1'b1; wvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      wvalid = 1'b0;
      chk($sformatf("wfirst wready c%0d", c), 32'(wready), 32'd0);
      chk($sformatf("wfirst awready c%0d", c), 32'(awready), 32'd1);
      chk($sformatf("wfirst bvalid c%0d", c), 32'(bvalid), 32'd0);
    end
    awaddr = 2'd2; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("wfirst bvalid early", 32'(bvalid), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall bvalid c%0d", c), 32'(bvalid), 32'd1);
      chk($sformatf("stall bresp c%0d", c), 32'(bresp), 32'd0);
      chk($sformatf("stall awready c%0d", c), 32'(awready), 32'd0);
      chk($sformatf("stall wready c%0d", c), 32'(wready), 32'd0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("stall release bvalid", 32'(bvalid), 32'd0);
    chk("stall release awready", 32'(awready), 32'd1);
    chk("stall release wready", 32'(wready), 32'd1);
    do_read(2'd2, 8'h5A, "reg2");

    // Commit to addr 0 on the same edge as AR addr 0: old value returned.
    @(negedge clk);
    awaddr = 2'd0; awvalid = 1'b1; wdata = 8'h22; wstrb = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 2'd0; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    chk("collide rvalid", 32'(rvalid), 32'd1);
    chk("collide rdata", 32'(rdata), 32'h11);
    chk("collide bvalid", 32'(bvalid), 32'd1);
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    do_read(2'd0, 8'h22, "collide after");

    // Reset while write FSM is in W_COMMIT and read FSM in R_DATA.
    @(negedge clk);
    awaddr = 2'd1; awvalid = 1'b1; wdata = 8'h99; wstrb = 1'b1; wvalid = 1'b1;
    araddr = 2'd1; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("pre-rst rvalid", 32'(rvalid), 32'd1);
    chk("pre-rst awready", 32'(awready), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("postrst bvalid c%0d", c), 32'(bvalid), 32'd0);
    end
    do_read(2'd0, 8'h00, "postrst r0");
    do_read(2'd1, 8'h00, "postrst r1");
    do_read(2'd2, 8'h00, "postrst r2");
`ifdef AXI4LITE_REGFILE_RO_ID_EN
    do_read(2'd3, 8'hA5, "postrst r3");
`else
    do_read(2'd3, 8'h00, "postrst r3");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
